pwconv_rescale_ctrl: RTL and testbench

- Sequencing controller for the pointwise-conv rescale/ReLU stage: a 2-stage, enable-gated pipeline of 4 lanes with 5-bit cnt and 4-bit pos sideband.
- Accepts accumulator beats from the PW MAC array over a valid/ready handshake and generates the cnt/pos tags for each beat.
- Drives the shared pipeline enable, tracks beat validity and last-flag through the pipeline, and applies downstream backpressure.
- Frames one layer pass of N_CNT x N_POS beats: start pulse in, done pulse out.

---
 rtl/pwconv_rescale_ctrl.sv | 116 +++++++++++
 tb/tb_pwconv_rescale_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwconv_rescale_ctrl.sv
// pwconv_rescale_ctrl: beat sequencing, cnt/pos tagging and drain control
// for the pointwise-conv rescale/ReLU pipeline.
module pwconv_rescale_ctrl #(
    parameter int N_CNT = 32,
    parameter int N_POS = 16,
    parameter int LAT   = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    input  logic       acc_valid,
    output logic       acc_ready,
    output logic       pipe_en,
    output logic [4:0] cnt_in,
    output logic [3:0] pos_in,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [4:0] CNT_MAX = 5'(N_CNT - 1);
    localparam logic [3:0] POS_MAX = 4'(N_POS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [3:0]     pos_q, pos_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] lst_q, lst_d;

    logic accept;
    logic last_beat;
    logic kill;

    assign out_valid = vld_q[LAT-1];
    assign out_last  = lst_q[LAT-1] & vld_q[LAT-1];
    assign pipe_en   = !(out_valid && !out_ready);
    assign acc_ready = (state_q == S_RUN) && pipe_en;
    assign accept    = acc_valid && acc_ready;
    assign last_beat = (cnt_q == CNT_MAX) && (pos_q == POS_MAX);
    assign kill      = abort && (state_q != S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign cnt_in    = cnt_q;
    assign pos_in    = pos_q;

    // Shift validity/last flags alongside the data on every enabled cycle.
    always_comb begin
        vld_d = vld_q;
        lst_d = lst_q;
        if (kill) begin
            vld_d = '0;
            lst_d = '0;
        end else if (pipe_en) begin
            vld_d = {vld_q[LAT-2:0], accept};
            lst_d = {lst_q[LAT-2:0], accept && last_beat};
        end
    end

    // Step the cnt/pos tags once per accepted beat, wrapping at frame end.
    always_comb begin
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (kill) begin
            cnt_d = '0;
            pos_d = '0;
        end else if (accept) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 4'd1;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // Frame sequencing; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (accept && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (vld_d == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
        end
    end

endmodule

// File: tb/tb_pwconv_rescale_ctrl.sv
// tb_pwconv_rescale_ctrl: directed frames against a tag/last scoreboard,
// plus a small 2x2 instance for the drain-hold case.
module tb_pwconv_rescale_ctrl;

    localparam int NC = 32;
    localparam int NP = 16;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start, abort, busy, done;
    logic       acc_valid, acc_ready, pipe_en;
    logic [4:0] cnt_in;
    logic [3:0] pos_in;
    logic       out_valid, out_last, out_ready;

    logic       b_start, b_abort, b_busy, b_done;
    logic       b_acc_valid, b_acc_ready, b_pipe_en;
    logic [4:0] b_cnt_in;
    logic [3:0] b_pos_in;
    logic       b_out_valid, b_out_last, b_out_ready;

    pwconv_rescale_ctrl #(.N_CNT(NC), .N_POS(NP), .LAT(2)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .busy(busy), .done(done), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .pipe_en(pipe_en), .cnt_in(cnt_in),
        .pos_in(pos_in), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready)
    );

    pwconv_rescale_ctrl #(.N_CNT(2), .N_POS(2), .LAT(2)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .acc_valid(b_acc_valid),
        .acc_ready(b_acc_ready), .pipe_en(b_pipe_en), .cnt_in(b_cnt_in),
        .pos_in(b_pos_in), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic last;
        int   acyc;
        logic strict;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   exp_pos = 0;
    int   acc_cnt = 0;
    int   acc_first = 0;
    int   acc_last = 0;
    int   hs_cnt = 0;
    int   last_hs = 0;
    int   done_cnt = 0;
    int   b_hs = 0;
    int   prev_cnt = 0;
    int   prev_pos = 0;
    logic strict = 1'b1;
    logic saw_wrap = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus side: every accepted beat pushes its expected last flag.
    always @(negedge clk) begin
        if (!rst_b || abort) begin
            exp_cnt = 0;
            exp_pos = 0;
        end else if (acc_valid && acc_ready) begin
            chk("cnt_in", int'(cnt_in), exp_cnt);
            chk("pos_in", int'(pos_in), exp_pos);
            if (prev_cnt == 31 && prev_pos == 3 && cnt_in == 0 && pos_in == 4)
                saw_wrap = 1'b1;
            prev_cnt = int'(cnt_in);
            prev_pos = int'(pos_in);
            q.push_back('{(exp_cnt == NC-1) && (exp_pos == NP-1), cyc, strict});
            if (acc_cnt == 0) acc_first = cyc;
            acc_last = cyc;
            acc_cnt++;
            if (exp_cnt == NC-1) begin
                exp_cnt = 0;
                exp_pos = (exp_pos == NP-1) ? 0 : exp_pos + 1;
            end else begin
                exp_cnt++;
            end
        end
    end

    // Monitor side: pop and compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("out_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_last", int'(out_last), int'(e.last));
                if (e.strict) chk("out_latency", cyc - e.acyc, 2);
            end
            hs_cnt++;
            last_hs = cyc;
        end
        if (done) begin
            done_cnt++;
            chk("done_latency", cyc - last_hs, 1);
        end
        if (!rst_b || abort) q.delete();
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            chk("b_out_last", int'(b_out_last), int'(b_hs == 3));
            b_hs++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic frame_prep(input logic s);
        strict  = s;
        acc_cnt = 0;
        hs_cnt  = 0;
    endtask

    task automatic frame_end();
        chk("frame_outputs", hs_cnt, NC*NP);
        chk("frame_accepts", acc_cnt, NC*NP);
        chk("queue_empty", q.size(), 0);
        chk("busy_after", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic idle_outputs(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_out_last"}, int'(out_last), 0);
        chk({nm, "_acc_ready"}, int'(acc_ready), 0);
        chk({nm, "_cnt"}, int'(cnt_in), 0);
        chk({nm, "_pos"}, int'(pos_in), 0);
    endtask

    initial begin
        int d0;
        int n;
        rst_b = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        acc_valid = 1'b0;
        out_ready = 1'b1;
        b_start = 1'b0;
        b_abort = 1'b0;
        b_acc_valid = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) tick();
        idle_outputs("reset");
        rst_b = 1'b1;
        repeat (2) tick();

        // 1: streaming frame, no stalls
        frame_prep(1'b1);
        acc_valid = 1'b1;
        pulse_start();
        wait_done(700);
        frame_end();
        chk("accepts_back_to_back", acc_last - acc_first, NC*NP - 1);
        acc_valid = 1'b0;
        repeat (3) tick();

        // 2: 5-cycle downstream stall mid-frame
        frame_prep(1'b0);
        acc_valid = 1'b1;
        pulse_start();
        repeat (50) tick();
        out_ready = 1'b0;
        repeat (5) begin
            #1;
            chk("stall_pipe_en", int'(pipe_en), 0);
            chk("stall_acc_ready", int'(acc_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_cnt", int'(cnt_in), exp_cnt);
            chk("stall_pos", int'(pos_in), exp_pos);
            tick();
        end
        out_ready = 1'b1;
        wait_done(700);
        frame_end();
        acc_valid = 1'b0;
        repeat (3) tick();

        // 3: upstream bubbles 1,0,0,1
        frame_prep(1'b1);
        saw_wrap = 1'b0;
        pulse_start();
        d0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            acc_valid = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        chk("bubble_done_seen", done_cnt - d0, 1);
        chk("wrap_31_3_to_0_4", int'(saw_wrap), 1);
        frame_end();
        acc_valid = 1'b0;
        repeat (3) tick();

        // 4: abort after 100 accepts, then a clean frame
        frame_prep(1'b1);
        acc_valid = 1'b1;
        pulse_start();
        n = 0;
        while (acc_cnt < 100 && n < 300) begin
            tick();
            n++;
        end
        chk("abort_point", acc_cnt, 100);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_outputs("abort");
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        frame_prep(1'b1);
        pulse_start();
        wait_done(700);
        frame_end();
        acc_valid = 1'b0;
        repeat (3) tick();

        // 5: start ignored in RUN, then reset mid-frame
        frame_prep(1'b1);
        acc_valid = 1'b1;
        pulse_start();
        repeat (40) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        repeat (20) tick();
        chk("restart_accepts", acc_cnt, 61);
        d0 = done_cnt;
        rst_b = 1'b0;
        #1;
        idle_outputs("midreset");
        tick();
        rst_b = 1'b1;
        repeat (5) tick();
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_idle_busy", int'(busy), 0);

        // 5b: start and abort together in IDLE -> start wins
        frame_prep(1'b1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_beats_abort", int'(busy), 1);
        wait_done(700);
        frame_end();
        acc_valid = 1'b0;
        repeat (3) tick();

        // 6: 2x2 frame, last beat held in DRAIN
        b_acc_valid = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (!(b_out_valid && b_out_last) && n < 20) begin
            tick();
            n++;
        end
        chk("b_last_reached", int'(b_out_last), 1);
        b_out_ready = 1'b0;
        repeat (4) begin
            #1;
            chk("b_hold_valid", int'(b_out_valid), 1);
            chk("b_hold_last", int'(b_out_last), 1);
            chk("b_hold_busy", int'(b_busy), 1);
            chk("b_hold_done", int'(b_done), 0);
            chk("b_hold_acc_ready", int'(b_acc_ready), 0);
            chk("b_hold_pipe_en", int'(b_pipe_en), 0);
            tick();
        end
        b_out_ready = 1'b1;
        tick();
        chk("b_done", int'(b_done), 1);
        chk("b_drained", int'(b_out_valid), 0);
        chk("b_busy_in_done", int'(b_busy), 0);
        tick();
        chk("b_done_pulse", int'(b_done), 0);
        chk("b_handshakes", b_hs, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
